// File: rtl/conv3x3_window_sched.sv
// Layer scheduler for one 3x3 signed MAC: walks a valid stride-1 window over an IMG_W x IMG_H map,
// streams 9 pixel/weight pairs per output pixel, then writes the MAC result to the output buffer.
module conv3x3_window_sched #(
    parameter int BITS    = 16,
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int AW      = 12,
    parameter int TIMEOUT = 64
) (
    input  logic                clk_in,
    input  logic                rst,
    input  logic                layer_start,
    input  logic [2*BITS-1:0]   bias_in,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [AW-1:0]       fm_addr,
    input  logic [BITS-1:0]     fm_rdata,
    output logic [3:0]          wt_addr,
    input  logic [BITS-1:0]     wt_rdata,
    output logic                mac_start,
    output logic [BITS-1:0]     mac_data,
    output logic [BITS-1:0]     mac_weight,
    output logic [2*BITS-1:0]   mac_bias,
    input  logic                mac_ready,
    input  logic [2*BITS+4:0]   mac_result,
    output logic                out_we,
    output logic [AW-1:0]       out_addr,
    output logic [2*BITS+4:0]   out_data
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [AW-1:0] IMG_W_A  = AW'(IMG_W);
    localparam logic [AW-1:0] OUT_W_A  = AW'(IMG_W - 2);
    localparam logic [AW-1:0] LAST_COL = AW'(IMG_W - 3);
    localparam logic [AW-1:0] LAST_ROW = AW'(IMG_H - 3);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    logic [2:0]          state;
    logic [AW-1:0]       row;
    logic [AW-1:0]       col;
    logic [3:0]          k;
    logic [1:0]          kx;
    logic [1:0]          ky;
    logic [TW-1:0]       timer;
    logic [2*BITS-1:0]   bias_q;
    logic [2*BITS+4:0]   out_data_q;
    logic                err_q;
    logic                mac_start_q;

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state       <= S_IDLE;
            row         <= '0;
            col         <= '0;
            k           <= '0;
            kx          <= '0;
            ky          <= '0;
            timer       <= '0;
            bias_q      <= '0;
            out_data_q  <= '0;
            err_q       <= 1'b0;
            mac_start_q <= 1'b0;
        end else begin
            mac_start_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (layer_start) begin
                        bias_q <= bias_in;
                        err_q  <= 1'b0;
                        row    <= '0;
                        col    <= '0;
                        k      <= '0;
                        kx     <= '0;
                        ky     <= '0;
                        state  <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // pair 0 reaches the MAC one cycle after its issue (RAM latency)
                    mac_start_q <= (k == 4'd0);
                    if (k == 4'd8) begin
                        k     <= '0;
                        kx    <= '0;
                        ky    <= '0;
                        state <= S_FEED;
                    end else begin
                        k <= k + 4'd1;
                        if (kx == 2'd2) begin
                            kx <= '0;
                            ky <= ky + 2'd1;
                        end else begin
                            kx <= kx + 2'd1;
                        end
                    end
                end
                S_FEED: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (mac_ready) begin
                        out_data_q <= mac_result;
                        state      <= S_WRITE;
                    end else if (timer == TMO_LAST) begin
                        err_q <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_WRITE: begin
                    if (col < LAST_COL) begin
                        col <= col + 1'b1;
                    end else begin
                        col <= '0;
                        row <= row + 1'b1;
                    end
                    if (row == LAST_ROW && col == LAST_COL) begin
                        state <= S_DONE;
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        fm_addr  = '0;
        wt_addr  = '0;
        out_addr = '0;
        if (state == S_ISSUE) begin
            fm_addr = (row + AW'(ky)) * IMG_W_A + col + AW'(kx);
            wt_addr = k;
        end
        if (state == S_WRITE) begin
            out_addr = row * OUT_W_A + col;
        end
    end

    assign busy       = (state != S_IDLE) && (state != S_DONE);
    assign done       = (state == S_DONE);
    assign out_we     = (state == S_WRITE);
    assign err        = err_q;
    assign mac_start  = mac_start_q;
    assign mac_data   = fm_rdata;
    assign mac_weight = wt_rdata;
    assign mac_bias   = bias_q;
    assign out_data   = out_data_q;

endmodule
